b01_frame_ctrl: RTL and testbench

Frame sequencer for the b01 serial-comparator FSM. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and puts b01 into state `a` via its reset. It then drives the operands LSB-first onto b01's `line1`/`line2` inputs, one bit per clock. It captures b01's `outp` stream into a result word, counts `overflw` pulses, and returns both over a second valid/ready handshake. It sits between the BIST/test host logic and one b01 instance, sequencing that instance frame by frame.

---
 rtl/b01_frame_ctrl_if.sv | 27 ++
 rtl/b01_frame_ctrl.sv | 116 +++++++++++
 tb/tb_b01_frame_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b01_frame_ctrl_if.sv
// Host-side bundle for b01_frame_ctrl: operand request handshake and result handshake.
//   start_valid/start_ready/op_a/op_b : operand pair offered by the host
//   res_valid/res_ready/res_data/ovf_count : captured result returned to the host
// master = host side, slave = frame controller side.
interface b01_frame_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [CNTW-1:0]  ovf_count;

    modport master (
        output start_valid, op_a, op_b, res_ready,
        input  start_ready, res_valid, res_data, ovf_count
    );

    modport slave (
        input  start_valid, op_a, op_b, res_ready,
        output start_ready, res_valid, res_data, ovf_count
    );
endinterface

// File: rtl/b01_frame_ctrl.sv
// Frame sequencer for one b01 serial-comparator instance.
// Accepts an operand pair, re-resets b01, drives the operands LSB-first onto line1/line2 one
// bit per clock, captures outp into a result word, counts overflw steps (saturating) and
// returns the result over a valid/ready handshake.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   bus          : host handshakes (slave modport of b01_frame_ctrl_if)
//   dut_reset    : registered reset to b01
//   line1, line2 : registered serial operand bits to b01
//   outp, overflw: b01 outputs, sampled at the end of each serial step
module b01_frame_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
) (
    input  logic            clock,
    input  logic            reset,
    b01_frame_ctrl_if.slave bus,
    output logic            dut_reset,
    output logic            line1,
    output logic            line2,
    input  logic            outp,
    input  logic            overflw
);
    localparam int unsigned     BITW    = $clog2(WIDTH);
    localparam logic [BITW-1:0] LAST    = BITW'(WIDTH - 1);
    localparam logic [CNTW-1:0] OVF_MAX = {CNTW{1'b1}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic [BITW-1:0]  cnt_q;
    logic [CNTW-1:0]  ovf_q;
    logic             start_ready_q;
    logic             res_valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            sa_q          <= '0;
            sb_q          <= '0;
            res_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= '0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            dut_reset     <= 1'b1;
            line1         <= 1'b0;
            line2         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start_valid) begin
                        state_q       <= StShift;
                        start_ready_q <= 1'b0;
                        dut_reset     <= 1'b0;
                        // Bit 0 goes straight onto the lines; the shift registers keep the rest.
                        line1         <= bus.op_a[0];
                        line2         <= bus.op_b[0];
                        sa_q          <= bus.op_a >> 1;
                        sb_q          <= bus.op_b >> 1;
                        cnt_q         <= '0;
                        res_q         <= '0;
                        ovf_q         <= '0;
                    end
                end
                StShift: begin
                    // outp enters at the MSB so step 0 ends up in bit 0 after WIDTH steps.
                    res_q <= {outp, res_q[WIDTH-1:1]};
                    if (overflw && (ovf_q != OVF_MAX)) begin
                        ovf_q <= ovf_q + CNTW'(1);
                    end
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    cnt_q <= cnt_q + BITW'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= StDone;
                        res_valid_q <= 1'b1;
                        line1       <= 1'b0;
                        line2       <= 1'b0;
                    end else begin
                        line1 <= sa_q[0];
                        line2 <= sb_q[0];
                    end
                end
                StDone: begin
                    if (bus.res_ready) begin
                        state_q       <= StIdle;
                        res_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        dut_reset     <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    res_valid_q   <= 1'b0;
                    start_ready_q <= 1'b1;
                    dut_reset     <= 1'b1;
                    line1         <= 1'b0;
                    line2         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_q;
    assign bus.ovf_count   = ovf_q;
endmodule

// File: tb/tb_b01_frame_ctrl.sv
// Bench for b01_frame_ctrl: two controllers (WIDTH=8/CNTW=4 and WIDTH=32/CNTW=2), each driving
// a behavioural b01 (combinational outp/overflw, reset to state a).
module tb_b01_frame_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum logic [2:0] {SA, SB, SC, SE, SF, SG, SWF0, SWF1} b01_st_t;

    function automatic b01_st_t b01_next(b01_st_t s, logic l1, logic l2);
        case (s)
            SA, SE:  return (l1 & l2) ? SF : SB;
            SB:      return (l1 & l2) ? SG : SC;
            SF:      return (l1 | l2) ? SG : SC;
            SC:      return (l1 & l2) ? SWF1 : SWF0;
            SG:      return (l1 | l2) ? SWF1 : SWF0;
            SWF0:    return (l1 & l2) ? SE : SA;
            default: return (l1 | l2) ? SE : SA;
        endcase
    endfunction

    function automatic logic b01_outp(b01_st_t s, logic l1, logic l2);
        if (s == SF || s == SG || s == SWF1) return ~(l1 ^ l2);
        return l1 ^ l2;
    endfunction

    // 8-bit controller and its b01
    b01_frame_ctrl_if #(.WIDTH(8), .CNTW(4)) bus8 ();
    logic dut_reset8, line1_8, line2_8, outp8, ovf8;
    b01_st_t st8;

    b01_frame_ctrl #(.WIDTH(8), .CNTW(4)) u_dut8 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus8),
        .dut_reset (dut_reset8),
        .line1     (line1_8),
        .line2     (line2_8),
        .outp      (outp8),
        .overflw   (ovf8)
    );

    always_ff @(posedge clock or posedge dut_reset8) begin
        if (dut_reset8) st8 <= SA;
        else            st8 <= b01_next(st8, line1_8, line2_8);
    end
    assign outp8 = b01_outp(st8, line1_8, line2_8);
    assign ovf8  = (st8 == SE);

    // 32-bit controller with a 2-bit overflow counter
    b01_frame_ctrl_if #(.WIDTH(32), .CNTW(2)) bus32 ();
    logic dut_reset32, line1_32, line2_32, outp32, ovf32;
    b01_st_t st32;

    b01_frame_ctrl #(.WIDTH(32), .CNTW(2)) u_dut32 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus32),
        .dut_reset (dut_reset32),
        .line1     (line1_32),
        .line2     (line2_32),
        .outp      (outp32),
        .overflw   (ovf32)
    );

    always_ff @(posedge clock or posedge dut_reset32) begin
        if (dut_reset32) st32 <= SA;
        else             st32 <= b01_next(st32, line1_32, line2_32);
    end
    assign outp32 = b01_outp(st32, line1_32, line2_32);
    assign ovf32  = (st32 == SE);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Handshake on the 8-bit controller; returns at E0+1 with the operands scrambled.
    task automatic start_frame8(input logic [7:0] a, input logic [7:0] b);
        int w = 0;
        while (bus8.start_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_checks++;
        if (bus8.start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_wait8: start_ready=%b required 1", bus8.start_ready);
        end
        bus8.op_a        = a;
        bus8.op_b        = b;
        bus8.start_valid = 1'b1;
        step();
        bus8.start_valid = 1'b0;
        bus8.op_a        = ~a;
        bus8.op_b        = ~b;
    endtask

    // Latency counted from the handshake cycle to the first cycle with res_valid.
    task automatic wait_result8(output int lat);
        lat = 1;
        while (bus8.res_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        n_checks++;
        if (bus8.res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL res_wait8: res_valid=%b required 1 within 100 cycles", bus8.res_valid);
        end
    endtask

    task automatic accept8();
        bus8.res_ready = 1'b1;
        step();
        bus8.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (bus8.start_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_start_ready: got %b required 1", bus8.start_ready);
        end
        n_checks++;
        if (dut_reset8 !== 1'b1) begin
            n_fail++; $display("FAIL rst_dut_reset: got %b required 1", dut_reset8);
        end
        n_checks++;
        if ({line1_8, line2_8} !== 2'b00) begin
            n_fail++; $display("FAIL rst_lines: got %b required 00", {line1_8, line2_8});
        end
        n_checks++;
        if (bus8.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_res_valid: got %b required 0", bus8.res_valid);
        end
        n_checks++;
        if (bus8.res_data !== 8'h00 || bus8.ovf_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_result: got %h/%0d required 00/0", bus8.res_data, bus8.ovf_count);
        end
        n_checks++;
        if (bus32.start_ready !== 1'b1 || dut_reset32 !== 1'b1 || bus32.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_dut32: got rdy=%b drst=%b vld=%b required 1 1 0",
                     bus32.start_ready, dut_reset32, bus32.res_valid);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_zero();
        int lat;
        start_frame8(8'h00, 8'h00);
        n_checks++;
        if (dut_reset8 !== 1'b0 || bus8.start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_step0: got drst=%b rdy=%b required 0 0",
                     dut_reset8, bus8.start_ready);
        end
        wait_result8(lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++; $display("FAIL zero_latency: got %0d required 9", lat);
        end
        n_checks++;
        if (bus8.res_data !== 8'h00 || bus8.ovf_count !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_result: got %h/%0d required 00/0", bus8.res_data, bus8.ovf_count);
        end
        accept8();
    endtask

    task automatic test_ones_zero();
        int lat;
        start_frame8(8'hFF, 8'h00);
        n_checks++;
        if ({line1_8, line2_8} !== 2'b10 || dut_reset8 !== 1'b0) begin
            n_fail++;
            $display("FAIL onezero_step0: got lines=%b drst=%b required 10 0",
                     {line1_8, line2_8}, dut_reset8);
        end
        wait_result8(lat);
        n_checks++;
        if (bus8.res_data !== 8'hFF || bus8.ovf_count !== 4'd0) begin
            n_fail++;
            $display("FAIL onezero_result: got %h/%0d required FF/0",
                     bus8.res_data, bus8.ovf_count);
        end
        n_checks++;
        if ({line1_8, line2_8} !== 2'b00) begin
            n_fail++; $display("FAIL done_lines: got %b required 00", {line1_8, line2_8});
        end
        accept8();
    endtask

    task automatic test_ones_ones();
        int lat;
        start_frame8(8'hFF, 8'hFF);
        wait_result8(lat);
        n_checks++;
        if (bus8.res_data !== 8'hEE || bus8.ovf_count !== 4'd1) begin
            n_fail++;
            $display("FAIL oneone_result: got %h/%0d required EE/1",
                     bus8.res_data, bus8.ovf_count);
        end
        accept8();
    endtask

    task automatic test_saturate();
        int lat = 1;
        bus32.op_a        = '1;
        bus32.op_b        = '1;
        bus32.start_valid = 1'b1;
        step();
        bus32.start_valid = 1'b0;
        while (bus32.res_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL sat_latency: got %0d required 33", lat);
        end
        n_checks++;
        if (bus32.ovf_count !== 2'd3) begin
            n_fail++; $display("FAIL sat_ovf: got %0d required 3", bus32.ovf_count);
        end
        n_checks++;
        if (bus32.res_data !== 32'hEEEE_EEEE) begin
            n_fail++; $display("FAIL sat_data: got %h required EEEEEEEE", bus32.res_data);
        end
        bus32.res_ready = 1'b1;
        step();
        bus32.res_ready = 1'b0;
        n_checks++;
        if (bus32.start_ready !== 1'b1 || bus32.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_accept: got rdy=%b vld=%b required 1 0",
                     bus32.start_ready, bus32.res_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_frame8(8'hFF, 8'hFF);
        wait_result8(lat);
        // Host already presents the next pair while the result is held off.
        bus8.op_a        = 8'hFF;
        bus8.op_b        = 8'hFF;
        bus8.start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus8.res_valid !== 1'b1 || bus8.res_data !== 8'hEE || bus8.ovf_count !== 4'd1
                || bus8.start_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: got vld=%b data=%h ovf=%0d rdy=%b required 1 EE 1 0",
                         i, bus8.res_valid, bus8.res_data, bus8.ovf_count, bus8.start_ready);
            end
            step();
        end
        bus8.res_ready = 1'b1;
        step();
        bus8.res_ready = 1'b0;
        n_checks++;
        if (bus8.start_ready !== 1'b1 || bus8.res_valid !== 1'b0 || dut_reset8 !== 1'b1
            || bus8.res_data !== 8'hEE) begin
            n_fail++;
            $display("FAIL b2b_idle: got rdy=%b vld=%b drst=%b data=%h required 1 0 1 EE",
                     bus8.start_ready, bus8.res_valid, dut_reset8, bus8.res_data);
        end
        step();
        bus8.start_valid = 1'b0;
        bus8.op_a        = 8'h00;
        bus8.op_b        = 8'h00;
        n_checks++;
        if (bus8.start_ready !== 1'b0 || dut_reset8 !== 1'b0 || {line1_8, line2_8} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_start: got rdy=%b drst=%b lines=%b required 0 0 11",
                     bus8.start_ready, dut_reset8, {line1_8, line2_8});
        end
        wait_result8(lat);
        n_checks++;
        if (lat !== 9 || bus8.res_data !== 8'hEE || bus8.ovf_count !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_result: got lat=%0d %h/%0d required 9 EE/1",
                     lat, bus8.res_data, bus8.ovf_count);
        end
        accept8();
    endtask

    task automatic test_midframe_reset();
        int lat;
        start_frame8(8'hFF, 8'h00);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_reset8 !== 1'b1 || bus8.res_valid !== 1'b0 || bus8.start_ready !== 1'b1
            || {line1_8, line2_8} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_state: got drst=%b vld=%b rdy=%b lines=%b required 1 0 1 00",
                     dut_reset8, bus8.res_valid, bus8.start_ready, {line1_8, line2_8});
        end
        #1;
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if (bus8.res_valid !== 1'b0 || bus8.start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_result: got vld=%b rdy=%b required 0 1",
                     bus8.res_valid, bus8.start_ready);
        end
        start_frame8(8'hFF, 8'h00);
        wait_result8(lat);
        n_checks++;
        if (bus8.res_data !== 8'hFF || bus8.ovf_count !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_next: got %h/%0d required FF/0", bus8.res_data, bus8.ovf_count);
        end
        accept8();
    endtask

    initial begin
        bus8.start_valid  = 1'b0;
        bus8.op_a         = '0;
        bus8.op_b         = '0;
        bus8.res_ready    = 1'b0;
        bus32.start_valid = 1'b0;
        bus32.op_a        = '0;
        bus32.op_b        = '0;
        bus32.res_ready   = 1'b0;
        #2;
        test_reset();
        test_zero();
        test_ones_zero();
        test_ones_ones();
        test_saturate();
        test_back_to_back();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
